ddr_recorder_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single DDR4 AXI4 write port among `NREQ` waveform recorders (ADC, magnitude, position streams). Each recorder requests one burst at a time with an address and length. The arbiter grants one requester, issues the AW beat, and steers that requester's data onto W until `WLAST`. It then waits for the B response and reports per-requester completion or error. The block sits between the recorder bank and the DDR4 controller AXI slave, in the AXI clock domain.

---
 rtl/ddr_recorder_wr_arbiter_if.sv | 47 ++++
 rtl/ddr_recorder_wr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ddr_recorder_wr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_recorder_wr_arbiter_if.sv
// rtl/ddr_recorder_wr_arbiter_if.sv - requester bank and AXI4 write-port signals of the DDR write arbiter
interface ddr_recorder_wr_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 35,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 8
);
    logic [NREQ-1:0]            reqValid;
    logic [NREQ*ADDR_WIDTH-1:0] reqAddr;
    logic [NREQ*LEN_WIDTH-1:0]  reqLen;
    logic [NREQ*DATA_WIDTH-1:0] reqData;
    logic [NREQ-1:0]            reqDataValid;
    logic [NREQ-1:0]            reqDataReady;
    logic [NREQ-1:0]            grant;
    logic [NREQ-1:0]            reqDone;
    logic [NREQ-1:0]            reqErr;
    logic [ADDR_WIDTH-1:0]      m_awaddr;
    logic [LEN_WIDTH-1:0]       m_awlen;
    logic                       m_awvalid;
    logic                       m_awready;
    logic [DATA_WIDTH-1:0]      m_wdata;
    logic                       m_wlast;
    logic                       m_wvalid;
    logic                       m_wready;
    logic [1:0]                 m_bresp;
    logic                       m_bvalid;
    logic                       m_bready;
    logic [31:0]                busyCount;

    modport master (
        input  reqValid, reqAddr, reqLen, reqData, reqDataValid,
        input  m_awready, m_wready, m_bresp, m_bvalid,
        output reqDataReady, grant, reqDone, reqErr,
        output m_awaddr, m_awlen, m_awvalid,
        output m_wdata, m_wlast, m_wvalid,
        output m_bready, busyCount
    );

    modport slave (
        output reqValid, reqAddr, reqLen, reqData, reqDataValid,
        output m_awready, m_wready, m_bresp, m_bvalid,
        input  reqDataReady, grant, reqDone, reqErr,
        input  m_awaddr, m_awlen, m_awvalid,
        input  m_wdata, m_wlast, m_wvalid,
        input  m_bready, busyCount
    );
endinterface

// File: rtl/ddr_recorder_wr_arbiter.sv
// rtl/ddr_recorder_wr_arbiter.sv - round-robin arbiter sharing one AXI4 write port among recorders
module ddr_recorder_wr_arbiter #(
    parameter int NREQ          = 4,
    parameter int ADDR_WIDTH    = 35,
    parameter int DATA_WIDTH    = 256,
    parameter int LEN_WIDTH     = 8,
    parameter int BRESP_TIMEOUT = 1023
) (
    input logic                        axiClk,
    input logic                        axiAresetn,
    ddr_recorder_wr_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CW    = IDX_W + 1;
    localparam int TO_W  = $clog2(BRESP_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BRESP_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]      rr, rr_nxt, gidx, sel_idx;
    logic [CW-1:0]         cand;
    logic                  sel_found;
    logic [ADDR_WIDTH-1:0] sel_addr, awaddr_q;
    logic [LEN_WIDTH-1:0]  sel_len, awlen_q, beat_cnt;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_dvalid;
    logic [TO_W-1:0]       to_cnt;
    logic                  aw_hs, w_hs, b_timeout, awvalid_q;
    logic [NREQ-1:0]       grant_q, done_q, err_q;
    logic [31:0]           busy_q;

    // Scan upward from rr with wrap; cand is one bit wider so rr+k never overflows.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr} + CW'(k);
            if (cand >= CW'(NREQ))
                cand = cand - CW'(NREQ);
            if (!sel_found && bus.reqValid[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        g_data   = '0;
        g_dvalid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_addr = bus.reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = bus.reqLen[i*LEN_WIDTH +: LEN_WIDTH];
            end
            if (gidx == IDX_W'(i)) begin
                g_data   = bus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
                g_dvalid = bus.reqDataValid[i];
            end
        end
    end

    assign aw_hs     = awvalid_q & bus.m_awready;
    assign w_hs      = bus.m_wvalid & bus.m_wready;
    assign b_timeout = !bus.m_bvalid && (to_cnt == TO_LAST);
    assign rr_nxt    = (gidx == IDX_LAST) ? '0 : gidx + IDX_W'(1);

    always_ff @(posedge axiClk or negedge axiAresetn) begin
        if (!axiAresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = ADDR;
            ADDR:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && bus.m_wlast) state_nxt = RESP;
            RESP:    if (bus.m_bvalid || b_timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // W channel is a zero-latency mux from the granted requester.
    always_comb begin
        bus.m_wvalid     = 1'b0;
        bus.m_wdata      = '0;
        bus.m_wlast      = 1'b0;
        bus.reqDataReady = '0;
        bus.m_bready     = 1'b0;
        case (state)
            DATA: begin
                bus.m_wvalid     = g_dvalid;
                bus.m_wdata      = g_data;
                bus.m_wlast      = (beat_cnt == awlen_q);
                bus.reqDataReady = grant_q & {NREQ{bus.m_wready}};
            end
            RESP:    bus.m_bready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge axiClk or negedge axiAresetn) begin
        if (!axiAresetn) begin
            rr        <= '0;
            gidx      <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            beat_cnt  <= '0;
            to_cnt    <= '0;
            busy_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (grant_q != '0 && busy_q != '1)
                busy_q <= busy_q + 32'd1;
            case (state)
                IDLE: if (sel_found) begin
                    gidx      <= sel_idx;
                    awaddr_q  <= sel_addr;
                    awlen_q   <= sel_len;
                    grant_q   <= NREQ'(1) << sel_idx;
                    awvalid_q <= 1'b1;
                end
                ADDR: if (aw_hs) begin
                    awvalid_q <= 1'b0;
                    beat_cnt  <= '0;
                end
                DATA: if (w_hs) begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                    if (bus.m_wlast)
                        to_cnt <= '0;
                end
                RESP: begin
                    if (bus.m_bvalid || b_timeout) begin
                        if (bus.m_bvalid && bus.m_bresp == 2'b00)
                            done_q <= grant_q;
                        else
                            err_q <= grant_q;
                        grant_q <= '0;
                        rr      <= rr_nxt;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.reqDone   = done_q;
    assign bus.reqErr    = err_q;
    assign bus.m_awaddr  = awaddr_q;
    assign bus.m_awlen   = awlen_q;
    assign bus.m_awvalid = awvalid_q;
    assign bus.busyCount = busy_q;
endmodule

// File: tb/tb_ddr_recorder_wr_arbiter.sv
// tb/tb_ddr_recorder_wr_arbiter.sv - directed bench for the DDR recorder write arbiter
module tb_ddr_recorder_wr_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 35;
    localparam int DW   = 256;
    localparam int LW   = 8;
    localparam int TO   = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ddr_recorder_wr_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    ddr_recorder_wr_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .BRESP_TIMEOUT(TO)
    ) dut (
        .axiClk(clk),
        .axiAresetn(rst_n),
        .bus(bus)
    );

    // Requesters drop reqValid combinationally on their own completion pulse.
    logic [NREQ-1:0] req_hold;
    assign bus.reqValid = req_hold & ~(bus.reqDone | bus.reqErr);

    int n_checks, n_pass;

    logic dv_en, gap_en, wr_tog, b_en;
    int   cyc, b_wait;
    int   src_idx [NREQ];

    logic [NREQ-1:0] src_hs, prev_grant;
    logic            wlast_hs, b_hs;
    int              w_beats, last_cnt, last_at, aw_cnt, bready_cyc, gcnt;
    logic [31:0]     w_log [64];
    int              done_cnt [NREQ];
    int              err_cnt [NREQ];
    int              glog [16];
    logic [AW-1:0]   aw_addr;
    logic [LW-1:0]   aw_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Slave-side model: requester data sources and the B channel, updated just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) src_idx[i] = 0;
            b_wait       = 0;
            bus.m_bvalid = 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (src_hs[i]) src_idx[i]++;
            if (b_hs) bus.m_bvalid = 1'b0;
            if (b_wait > 0) begin
                b_wait--;
                if (b_wait == 0) bus.m_bvalid = 1'b1;
            end
            if (wlast_hs && b_en) b_wait = 2;
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.reqData[i*DW +: DW]  = {{(DW-32){1'b0}}, 8'(i), 24'(src_idx[i])};
            bus.reqDataValid[i]      = dv_en & (!gap_en | (cyc % 3 != 0));
        end
        bus.m_wready = !wr_tog | (cyc % 2 == 1);
    end

    always @(negedge clk) begin
        src_hs   = bus.reqDataReady & bus.reqDataValid;
        wlast_hs = bus.m_wvalid & bus.m_wready & bus.m_wlast;
        b_hs     = bus.m_bvalid & bus.m_bready;
        if (bus.m_wvalid && bus.m_wready) begin
            if (w_beats < 64) w_log[w_beats] = bus.m_wdata[31:0];
            w_beats++;
            if (bus.m_wlast) begin
                last_cnt++;
                last_at = w_beats;
            end
        end
        if (bus.m_awvalid && bus.m_awready) begin
            aw_addr = bus.m_awaddr;
            aw_len  = bus.m_awlen;
            aw_cnt++;
        end
        if (bus.m_bready) bready_cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.reqDone[i]) done_cnt[i]++;
            if (bus.reqErr[i])  err_cnt[i]++;
        end
        if (bus.grant != prev_grant && bus.grant != '0 && gcnt < 16) begin
            for (int i = 0; i < NREQ; i++)
                if (bus.grant[i]) glog[gcnt] = i;
            gcnt++;
        end
        prev_grant = bus.grant;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        w_beats = 0; last_cnt = 0; last_at = 0; aw_cnt = 0; bready_cyc = 0; gcnt = 0;
        aw_addr = '0; aw_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            done_cnt[i] = 0;
            err_cnt[i]  = 0;
        end
    endtask

    task automatic do_reset();
        req_hold = '0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        dv_en = 1'b1; gap_en = 1'b0; wr_tog = 1'b0; b_en = 1'b1;
        bus.m_awready = 1'b1;
        bus.m_bresp   = 2'b00;
        clear_log();
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        bus.reqAddr[i*AW +: AW] = addr;
        bus.reqLen[i*LW +: LW]  = len;
    endtask

    task automatic wait_fin(input int i, input int budget, input string tag);
        int n = 0;
        while (done_cnt[i] + err_cnt[i] == 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(done_cnt[i] + err_cnt[i] != 0), 64'd1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int n = 0;
        while (w_beats < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(w_beats >= target), 64'd1);
    endtask

    task automatic wait_grant(input int budget, input string tag);
        int n = 0;
        while (bus.grant == '0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(bus.grant != '0), 64'd1);
    endtask

    task automatic check_order(input int idx, input int beats, input string tag);
        int bad = 0;
        for (int k = 0; k < beats; k++)
            if (w_log[k] !== {8'(idx), 24'(k)}) bad++;
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; b_wait = 0;
        req_hold = '0; src_hs = '0; prev_grant = '0; wlast_hs = 1'b0; b_hs = 1'b0;
        dv_en = 1'b1; gap_en = 1'b0; wr_tog = 1'b0; b_en = 1'b1;
        bus.reqAddr = '0; bus.reqLen = '0; bus.reqData = '0; bus.reqDataValid = '0;
        bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_bresp = 2'b00; bus.m_bvalid = 1'b0;
        for (int i = 0; i < NREQ; i++) src_idx[i] = 0;
        clear_log();
        #1;
        do_reset();

        check("rst_grant",   64'(bus.grant), 64'd0);
        check("rst_awvalid", 64'(bus.m_awvalid), 64'd0);
        check("rst_awaddr",  64'(bus.m_awaddr), 64'd0);
        check("rst_awlen",   64'(bus.m_awlen), 64'd0);
        check("rst_wvalid",  64'(bus.m_wvalid), 64'd0);
        check("rst_bready",  64'(bus.m_bready), 64'd0);
        check("rst_busy",    64'(bus.busyCount), 64'd0);

        // single requester, 16-beat burst
        set_req(2, 35'h0010_0000, 8'd15);
        req_hold[2] = 1'b1;
        wait_fin(2, 200, "single_fin");
        req_hold = '0;
        step();
        check("single_awaddr", 64'(aw_addr), 64'h10_0000);
        check("single_awlen",  64'(aw_len), 64'd15);
        check("single_awcnt",  64'(aw_cnt), 64'd1);
        check("single_beats",  64'(w_beats), 64'd16);
        check("single_lastcnt", 64'(last_cnt), 64'd1);
        check("single_lastat", 64'(last_at), 64'd16);
        check_order(2, 16, "single_order");
        check("single_done",   64'(done_cnt[2]), 64'd1);
        check("single_err",    64'(err_cnt[2]), 64'd0);
        check("single_grant0", 64'(bus.grant), 64'd0);
        check("single_busy",   64'(bus.busyCount), 64'd20);

        // fairness, all requesters continuously valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 35'(i * 'h1000), 8'd0);
        req_hold = '1;
        begin
            int n = 0;
            while (gcnt < 8 && n < 200) begin
                step();
                n++;
            end
        end
        req_hold = '0;
        check("fair_gcnt", 64'(gcnt >= 8), 64'd1);
        for (int k = 0; k < 8; k++)
            check($sformatf("fair_grant%0d", k), 64'(glog[k]), 64'(k % 4));

        // backpressure on AW and W, data gaps
        do_reset();
        set_req(1, 35'h0000_2000, 8'd7);
        bus.m_awready = 1'b0;
        gap_en = 1'b1;
        wr_tog = 1'b1;
        req_hold[1] = 1'b1;
        wait_grant(10, "bp_grant");
        repeat (5) step();
        check("bp_no_w_before_aw", 64'(w_beats), 64'd0);
        check("bp_awvalid_held",   64'(bus.m_awvalid), 64'd1);
        bus.m_awready = 1'b1;
        wait_fin(1, 300, "bp_fin");
        req_hold = '0;
        step();
        check("bp_awaddr",  64'(aw_addr), 64'h2000);
        check("bp_beats",   64'(w_beats), 64'd8);
        check("bp_lastcnt", 64'(last_cnt), 64'd1);
        check("bp_lastat",  64'(last_at), 64'd8);
        check_order(1, 8, "bp_order");
        check("bp_done",    64'(done_cnt[1]), 64'd1);

        // SLVERR response
        do_reset();
        set_req(3, 35'h40, 8'd0);
        bus.m_bresp = 2'b10;
        req_hold[3] = 1'b1;
        wait_fin(3, 100, "slverr_fin");
        req_hold = '0;
        step();
        check("slverr_err",    64'(err_cnt[3]), 64'd1);
        check("slverr_done",   64'(done_cnt[3]), 64'd0);
        check("slverr_grant0", 64'(bus.grant), 64'd0);

        // B response never arrives
        do_reset();
        set_req(0, 35'h80, 8'd0);
        b_en = 1'b0;
        req_hold[0] = 1'b1;
        wait_fin(0, 100, "to_fin");
        req_hold = '0;
        step();
        check("to_resp_cycles", 64'(bready_cyc), 64'd15);
        check("to_err",         64'(err_cnt[0]), 64'd1);
        check("to_done",        64'(done_cnt[0]), 64'd0);
        check("to_grant0",      64'(bus.grant), 64'd0);
        check("to_bready0",     64'(bus.m_bready), 64'd0);

        // reset in the middle of DATA, rr must restart at 0
        do_reset();
        set_req(1, 35'h100, 8'd0);
        req_hold[1] = 1'b1;
        wait_fin(1, 100, "mid_pre_fin");
        req_hold = '0;
        step();
        set_req(3, 35'h300, 8'd7);
        req_hold[3] = 1'b1;
        wait_beats(3, 100, "mid_beats");
        rst_n = 1'b0;
        #1;
        check("mid_grant",   64'(bus.grant), 64'd0);
        check("mid_awvalid", 64'(bus.m_awvalid), 64'd0);
        check("mid_wvalid",  64'(bus.m_wvalid), 64'd0);
        check("mid_dready",  64'(bus.reqDataReady), 64'd0);
        check("mid_bready",  64'(bus.m_bready), 64'd0);
        check("mid_busy",    64'(bus.busyCount), 64'd0);
        check("mid_awaddr",  64'(bus.m_awaddr), 64'd0);
        req_hold = '0;
        step();
        step();
        rst_n = 1'b1;
        clear_log();
        set_req(0, 35'h500, 8'd0);
        req_hold = 4'b1001;
        wait_grant(10, "mid_regrant");
        check("mid_grant_req0", 64'(bus.grant), 64'd1);

        // granted requester drops reqValid during DATA
        do_reset();
        set_req(2, 35'h600, 8'd15);
        set_req(3, 35'h700, 8'd0);
        req_hold[2] = 1'b1;
        wait_beats(3, 50, "drop_beats");
        req_hold = '0;
        wait_fin(2, 100, "drop_fin");
        step();
        check("drop_beats16", 64'(w_beats), 64'd16);
        check("drop_done",    64'(done_cnt[2]), 64'd1);
        req_hold = 4'b1100;
        wait_grant(10, "drop_regrant");
        check("drop_rr_next", 64'(bus.grant), 64'b1000);
        req_hold = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
